// File: rtl/router_switch_ctrl.sv
// N-port router switch controller: round-robin service of single-flit input FIFOs,
// TTL/mask header check, TTL decrement and all-or-nothing multicast to the output FIFOs.
module router_switch_ctrl #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned NUM_PORTS  = 4,
    parameter int unsigned TTL_LSB    = 7,
    parameter int unsigned TTL_W      = 2,
    parameter int unsigned MASK_LSB   = 9,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              enable,
    input  logic [NUM_PORTS-1:0]              in_empty,
    output logic [NUM_PORTS-1:0]              in_rd,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]   in_data,
    input  logic [NUM_PORTS-1:0]              out_full,
    output logic [NUM_PORTS-1:0]              out_we,
    output logic [DATA_WIDTH-1:0]             out_data,
    output logic                              busy,
    output logic [$clog2(NUM_PORTS)-1:0]      cur_src,
    output logic [CNT_W-1:0]                  fwd_cnt,
    output logic [CNT_W-1:0]                  drop_cnt
);

    localparam int unsigned SRC_W = $clog2(NUM_PORTS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_LATCH,
        S_WRITE,
        S_DROP
    } state_e;

    state_e                 state_q, state_d;
    logic [SRC_W-1:0]       cur_src_q, cur_src_d;
    logic [SRC_W-1:0]       rr_q, rr_d;
    logic [SRC_W-1:0]       sel;
    logic                   sel_vld;
    logic [SRC_W:0]         idx;
    logic [DATA_WIDTH-1:0]  pkt_q, pkt_d;
    logic [DATA_WIDTH-1:0]  hdr;
    logic [NUM_PORTS-1:0]   tgt_q, tgt_d;
    logic [NUM_PORTS-1:0]   in_rd_q, in_rd_d;
    logic [NUM_PORTS-1:0]   out_we_q, out_we_d;
    logic [NUM_PORTS-1:0]   mask;
    logic [TTL_W-1:0]       ttl;
    logic                   busy_q, busy_d;
    logic [CNT_W-1:0]       fwd_q, fwd_d;
    logic [CNT_W-1:0]       drop_q, drop_d;

    // First non-empty port at or above the round-robin pointer, with wrap
    always_comb begin
        sel     = '0;
        sel_vld = 1'b0;
        idx     = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            idx = {1'b0, rr_q} + (SRC_W+1)'(i);
            if (idx >= (SRC_W+1)'(NUM_PORTS)) begin
                idx = idx - (SRC_W+1)'(NUM_PORTS);
            end
            if (!sel_vld && !in_empty[SRC_W'(idx)]) begin
                sel     = SRC_W'(idx);
                sel_vld = 1'b1;
            end
        end
    end

    always_comb begin
        hdr = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            if (cur_src_q == SRC_W'(p)) begin
                hdr = in_data[p*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign ttl  = hdr[TTL_LSB +: TTL_W];
    assign mask = hdr[MASK_LSB +: NUM_PORTS];

    always_comb begin
        state_d   = state_q;
        cur_src_d = cur_src_q;
        rr_d      = rr_q;
        pkt_d     = pkt_q;
        tgt_d     = tgt_q;
        in_rd_d   = '0;
        out_we_d  = '0;
        fwd_d     = fwd_q;
        drop_d    = drop_q;

        unique case (state_q)
            S_IDLE: begin
                if (enable && sel_vld) begin
                    cur_src_d = sel;
                    rr_d      = (sel == SRC_W'(NUM_PORTS - 1)) ? '0 : sel + 1'b1;
                    in_rd_d   = NUM_PORTS'(1) << sel;
                    state_d   = S_READ;
                end
            end
            S_READ: begin
                state_d = S_LATCH;
            end
            S_LATCH: begin
                if ((ttl == '0) || (mask == '0)) begin
                    state_d = S_DROP;
                end else begin
                    pkt_d                      = hdr;
                    pkt_d[TTL_LSB +: TTL_W]    = ttl - 1'b1;
                    tgt_d                      = mask;
                    // Write strobes are registered, so the full check is made one edge ahead
                    if ((mask & out_full) == '0) begin
                        out_we_d = mask;
                    end
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (out_we_q != '0) begin
                    fwd_d   = (fwd_q == '1) ? fwd_q : fwd_q + 1'b1;
                    state_d = S_IDLE;
                end else if ((tgt_q & out_full) == '0) begin
                    out_we_d = tgt_q;
                end
            end
            S_DROP: begin
                drop_d  = (drop_q == '1) ? drop_q : drop_q + 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cur_src_q <= '0;
            rr_q      <= '0;
            pkt_q     <= '0;
            tgt_q     <= '0;
            in_rd_q   <= '0;
            out_we_q  <= '0;
            busy_q    <= 1'b0;
            fwd_q     <= '0;
            drop_q    <= '0;
        end else begin
            state_q   <= state_d;
            cur_src_q <= cur_src_d;
            rr_q      <= rr_d;
            pkt_q     <= pkt_d;
            tgt_q     <= tgt_d;
            in_rd_q   <= in_rd_d;
            out_we_q  <= out_we_d;
            busy_q    <= busy_d;
            fwd_q     <= fwd_d;
            drop_q    <= drop_d;
        end
    end

    assign in_rd    = in_rd_q;
    assign out_we   = out_we_q;
    assign out_data = pkt_q;
    assign busy     = busy_q;
    assign cur_src  = cur_src_q;
    assign fwd_cnt  = fwd_q;
    assign drop_cnt = drop_q;

endmodule
